// File: rtl/dram_sequencer.sv
// GR8RAM DRAM sequencer: arbitrates host RAS/CAS accesses against CAS-before-RAS refresh.
// Latency: ack 3+T_CAS cycles after accept; backpressure: host_req is held until host_ack, refresh debt waits for slot_ok.
module dram_sequencer #(
    parameter int REF_INTERVAL = 91,
    parameter int REF_DEBT_MAX = 4,
    parameter int T_CAS        = 2,
    parameter int T_RAS        = 2,
    parameter int T_RP         = 1
) (
    input  logic        C7M,
    input  logic        RES,
    input  logic        slot_ok,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [22:0] host_addr,
    output logic        host_ack,
    output logic        rd_strobe,
    output logic [10:0] ra,
    output logic        nRAS,
    output logic        nCAS0,
    output logic        nCAS1,
    output logic        nRWE,
    output logic        busy,
    output logic [2:0]  ref_debt,
    output logic        ref_overflow
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ROW  = 3'd1;
    localparam logic [2:0] ST_RAS  = 3'd2;
    localparam logic [2:0] ST_COL  = 3'd3;
    localparam logic [2:0] ST_CAS  = 3'd4;
    localparam logic [2:0] ST_RCAS = 3'd5;
    localparam logic [2:0] ST_RRAS = 3'd6;
    localparam logic [2:0] ST_PRE  = 3'd7;

    localparam int CNT_W = 8;
    localparam int TMR_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       ref_debt_q, ref_debt_d;
    logic             ref_overflow_q, ref_overflow_d;
    logic             we_q, we_d;
    logic             bank_q, bank_d;
    logic [10:0]      row_q, row_d;
    logic [10:0]      col_q, col_d;
    logic [10:0]      ra_q, ra_d;
    logic             nras_q, nras_d;
    logic             ncas0_q, ncas0_d;
    logic             ncas1_q, ncas1_d;
    logic             nrwe_q, nrwe_d;
    logic             busy_q, busy_d;
    logic             host_ack_q, host_ack_d;
    logic             rd_strobe_q, rd_strobe_d;

    logic urgent;
    logic accept;
    logic debt_inc;
    logic debt_dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        accept  = 1'b0;
        urgent  = (ref_debt_q == 3'(REF_DEBT_MAX));
        case (state_q)
            ST_IDLE: begin
                if (urgent) begin
                    state_d = ST_RCAS;
                end else if (host_req) begin
                    accept  = 1'b1;
                    state_d = ST_ROW;
                end else if ((ref_debt_q != 3'd0) && slot_ok) begin
                    state_d = ST_RCAS;
                end
            end
            ST_ROW:  state_d = ST_RAS;
            ST_RAS:  state_d = ST_COL;
            ST_COL:  state_d = ST_CAS;
            ST_CAS: begin
                if (cnt_q == CNT_W'(T_CAS - 1)) state_d = ST_PRE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            ST_RCAS: state_d = ST_RRAS;
            ST_RRAS: begin
                if (cnt_q == CNT_W'(T_RAS - 1)) state_d = ST_PRE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            ST_PRE: begin
                if (cnt_q == CNT_W'(T_RP - 1)) state_d = ST_IDLE;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured only at accept so late host_addr/host_we changes are ignored.
    always_comb begin
        we_d   = we_q;
        bank_d = bank_q;
        row_d  = row_q;
        col_d  = col_q;
        if (accept) begin
            we_d   = host_we;
            bank_d = host_addr[22];
            row_d  = host_addr[21:11];
            col_d  = host_addr[10:0];
        end
    end

    always_comb begin
        debt_inc       = (tmr_q == TMR_W'(REF_INTERVAL - 1));
        debt_dec       = (state_q == ST_RRAS) && (state_d == ST_PRE);
        tmr_d          = debt_inc ? '0 : tmr_q + 1'b1;
        ref_debt_d     = ref_debt_q;
        ref_overflow_d = ref_overflow_q;
        if (debt_inc && !debt_dec) begin
            if (ref_debt_q == 3'(REF_DEBT_MAX)) ref_overflow_d = 1'b1;
            else                                ref_debt_d     = ref_debt_q + 3'd1;
        end else if (debt_dec && !debt_inc) begin
            ref_debt_d = ref_debt_q - 3'd1;
        end
    end

    // Pin values are decoded from the next state so every output is a flop.
    always_comb begin
        ra_d    = '0;
        nras_d  = 1'b1;
        ncas0_d = 1'b1;
        ncas1_d = 1'b1;
        nrwe_d  = 1'b1;
        case (state_d)
            ST_ROW: ra_d = row_d;
            ST_RAS: begin
                ra_d   = row_d;
                nras_d = 1'b0;
            end
            ST_COL: begin
                ra_d   = col_d;
                nras_d = 1'b0;
                nrwe_d = ~we_d;
            end
            ST_CAS: begin
                ra_d    = col_d;
                nras_d  = 1'b0;
                nrwe_d  = ~we_d;
                ncas0_d = bank_d;
                ncas1_d = ~bank_d;
            end
            ST_RCAS: begin
                ncas0_d = 1'b0;
                ncas1_d = 1'b0;
            end
            ST_RRAS: begin
                nras_d  = 1'b0;
                ncas0_d = 1'b0;
                ncas1_d = 1'b0;
            end
            default: ;
        endcase
        busy_d      = (state_d != ST_IDLE);
        host_ack_d  = (state_d == ST_CAS) && (cnt_d == CNT_W'(T_CAS - 1));
        rd_strobe_d = host_ack_d && !we_d;
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            tmr_q          <= '0;
            ref_debt_q     <= '0;
            ref_overflow_q <= 1'b0;
            we_q           <= 1'b0;
            bank_q         <= 1'b0;
            row_q          <= '0;
            col_q          <= '0;
            ra_q           <= '0;
            nras_q         <= 1'b1;
            ncas0_q        <= 1'b1;
            ncas1_q        <= 1'b1;
            nrwe_q         <= 1'b1;
            busy_q         <= 1'b0;
            host_ack_q     <= 1'b0;
            rd_strobe_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmr_q          <= tmr_d;
            ref_debt_q     <= ref_debt_d;
            ref_overflow_q <= ref_overflow_d;
            we_q           <= we_d;
            bank_q         <= bank_d;
            row_q          <= row_d;
            col_q          <= col_d;
            ra_q           <= ra_d;
            nras_q         <= nras_d;
            ncas0_q        <= ncas0_d;
            ncas1_q        <= ncas1_d;
            nrwe_q         <= nrwe_d;
            busy_q         <= busy_d;
            host_ack_q     <= host_ack_d;
            rd_strobe_q    <= rd_strobe_d;
        end
    end

    assign host_ack     = host_ack_q;
    assign rd_strobe    = rd_strobe_q;
    assign ra           = ra_q;
    assign nRAS         = nras_q;
    assign nCAS0        = ncas0_q;
    assign nCAS1        = ncas1_q;
    assign nRWE         = nrwe_q;
    assign busy         = busy_q;
    assign ref_debt     = ref_debt_q;
    assign ref_overflow = ref_overflow_q;

endmodule

// File: tb/tb_dram_sequencer.sv
// Randomized bench for dram_sequencer: a cycle-offset reference model predicts pins, acks and refreshes;
// a monitor pops expected acks/refreshes when the DUT presents them.
module tb_dram_sequencer;

    localparam int REF_INTERVAL = 91;
    localparam int REF_DEBT_MAX = 4;
    localparam int T_CAS        = 2;
    localparam int T_RAS        = 2;
    localparam int T_RP         = 1;
    localparam int HOST_LEN     = 4 + T_CAS + T_RP;
    localparam int REF_LEN      = 2 + T_RAS + T_RP;

    logic        C7M;
    logic        RES;
    logic        slot_ok;
    logic        host_req;
    logic        host_we;
    logic [22:0] host_addr;
    logic        host_ack;
    logic        rd_strobe;
    logic [10:0] ra;
    logic        nRAS, nCAS0, nCAS1, nRWE, busy;
    logic [2:0]  ref_debt;
    logic        ref_overflow;

    logic        f_ack, f_rd, f_nras, f_ncas0, f_ncas1, f_nrwe, f_busy, f_ovf;
    logic [10:0] f_ra;
    logic [2:0]  f_debt;
    logic        zero_bit;

    dram_sequencer #(
        .REF_INTERVAL(REF_INTERVAL), .REF_DEBT_MAX(REF_DEBT_MAX),
        .T_CAS(T_CAS), .T_RAS(T_RAS), .T_RP(T_RP)
    ) dut (
        .C7M(C7M), .RES(RES), .slot_ok(slot_ok), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_ack(host_ack), .rd_strobe(rd_strobe), .ra(ra),
        .nRAS(nRAS), .nCAS0(nCAS0), .nCAS1(nCAS1), .nRWE(nRWE), .busy(busy),
        .ref_debt(ref_debt), .ref_overflow(ref_overflow)
    );

    // A short refresh interval makes debt outrun refresh so saturation overflow is reachable.
    dram_sequencer #(
        .REF_INTERVAL(4), .REF_DEBT_MAX(REF_DEBT_MAX),
        .T_CAS(T_CAS), .T_RAS(T_RAS), .T_RP(T_RP)
    ) dut_fast (
        .C7M(C7M), .RES(RES), .slot_ok(zero_bit), .host_req(zero_bit), .host_we(zero_bit),
        .host_addr(23'd0), .host_ack(f_ack), .rd_strobe(f_rd), .ra(f_ra),
        .nRAS(f_nras), .nCAS0(f_ncas0), .nCAS1(f_ncas1), .nRWE(f_nrwe), .busy(f_busy),
        .ref_debt(f_debt), .ref_overflow(f_ovf)
    );

    typedef struct {
        int cyc;
        bit rd;
    } ack_exp_t;

    ack_exp_t hq[$];
    int       rq[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       slot_mode = 0;

    initial begin
        C7M = 1'b0;
        forever #5 C7M = ~C7M;
    end

    always @(posedge C7M) cyc <= cyc + 1;

    always @(posedge C7M) begin
        #1;
        case (slot_mode)
            0:       slot_ok = 1'b0;
            1:       slot_ok = 1'b1;
            default: slot_ok = 1'($urandom);
        endcase
    end

    // Reference model: an activity has a start cycle; pins follow from the offset into it.
    int          m_mode = 0;
    int          m_s = 0;
    int          m_debt = 0;
    int          m_rc = 0;
    bit          m_ovf = 0;
    bit          m_valid = 0;
    bit          m_we = 0;
    bit          m_bank = 0;
    logic [10:0] m_row = '0;
    logic [10:0] m_col = '0;

    always @(negedge C7M) begin
        int          k;
        logic [10:0] e_ra;
        logic [8:0]  e_pins, g_pins;
        bit          e_ras, e_c0, e_c1, e_wen, ra_chk, inc, dec;
        if (m_valid) begin
            k = cyc - m_s;
            if (m_mode == 1 && k >= HOST_LEN) m_mode = 0;
            if (m_mode == 2 && k >= REF_LEN)  m_mode = 0;
            e_ra = '0; e_ras = 1; e_c0 = 1; e_c1 = 1; e_wen = 1; ra_chk = 0;
            if (m_mode == 1) begin
                if (k <= 2) begin
                    e_ra = m_row; e_ras = (k == 1); ra_chk = 1;
                end else if (k <= 3 + T_CAS) begin
                    e_ra = m_col; e_ras = 0; e_wen = !m_we; ra_chk = 1;
                    if (k >= 4) begin
                        if (m_bank) e_c1 = 0;
                        else        e_c0 = 0;
                    end
                end
            end else if (m_mode == 2 && k <= 1 + T_RAS) begin
                e_c0 = 0; e_c1 = 0; e_ras = (k == 1); ra_chk = 1;
            end
            e_pins = {e_ras, e_c0, e_c1, e_wen, (m_mode != 0), 3'(m_debt), m_ovf};
            g_pins = {nRAS, nCAS0, nCAS1, nRWE, busy, ref_debt, ref_overflow};
            checks++;
            if (g_pins !== e_pins) begin
                errors++;
                $display("FAIL pins cyc=%0d got {nRAS,nCAS0,nCAS1,nRWE,busy,debt,ovf}=%b want=%b", cyc, g_pins, e_pins);
            end
            if (ra_chk) begin
                checks++;
                if (ra !== e_ra) begin
                    errors++;
                    $display("FAIL ra cyc=%0d got=%h want=%h", cyc, ra, e_ra);
                end
            end
        end
        if (RES === 1'b1) begin
            m_valid = 1; m_mode = 0; m_debt = 0; m_ovf = 0; m_rc = cyc + 1;
            hq.delete();
            rq.delete();
        end else if (m_valid) begin
            k   = cyc - m_s;
            inc = ((cyc - m_rc) % REF_INTERVAL) == REF_INTERVAL - 1;
            dec = (m_mode == 2) && (k == 1 + T_RAS);
            if (m_mode == 0) begin
                if (m_debt == REF_DEBT_MAX || (!host_req && m_debt > 0 && slot_ok)) begin
                    m_mode = 2; m_s = cyc;
                    rq.push_back(cyc + 1);
                end else if (host_req) begin
                    m_mode = 1; m_s = cyc;
                    m_we = host_we; m_bank = host_addr[22];
                    m_row = host_addr[21:11]; m_col = host_addr[10:0];
                    hq.push_back('{cyc: cyc + 3 + T_CAS, rd: !host_we});
                end
            end
            if (inc && !dec) begin
                if (m_debt == REF_DEBT_MAX) m_ovf = 1;
                else                        m_debt++;
            end else if (dec && !inc) begin
                m_debt--;
            end
        end
    end

    // Monitor: pops an expected ack / refresh start whenever the DUT presents one.
    always @(negedge C7M) begin
        ack_exp_t a;
        int       r;
        if (m_valid) begin
            while (hq.size() > 0 && hq[0].cyc < cyc) begin
                a = hq.pop_front();
                checks++; errors++;
                $display("FAIL missing_ack got=none want_cyc=%0d", a.cyc);
            end
            while (rq.size() > 0 && rq[0] < cyc) begin
                r = rq.pop_front();
                checks++; errors++;
                $display("FAIL missing_refresh got=none want_cyc=%0d", r);
            end
            if (host_ack === 1'b1) begin
                checks++;
                if (hq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack got_cyc=%0d want=none", cyc);
                end else begin
                    a = hq.pop_front();
                    if (a.cyc != cyc || rd_strobe !== a.rd) begin
                        errors++;
                        $display("FAIL ack got cyc=%0d rd=%b want cyc=%0d rd=%b", cyc, rd_strobe, a.cyc, a.rd);
                    end
                end
            end else if (rd_strobe !== 1'b0) begin
                checks++; errors++;
                $display("FAIL stray_rd_strobe cyc=%0d got=%b want=0", cyc, rd_strobe);
            end
            if (nRAS === 1'b1 && nCAS0 === 1'b0 && nCAS1 === 1'b0) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_refresh got_cyc=%0d want=none", cyc);
                end else begin
                    r = rq.pop_front();
                    if (r != cyc) begin
                        errors++;
                        $display("FAIL refresh_start got=%0d want=%0d", cyc, r);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge C7M);
        #1;
    endtask

    task automatic do_reset(output int rc);
        RES = 1'b1;
        step();
        RES = 1'b0;
        rc = cyc;
    endtask

    task automatic wait_neg(input int t);
        do @(negedge C7M); while (cyc < t);
    endtask

    task automatic host_xfer(input logic [22:0] a, input logic w, input bit early);
        bit got;
        bit sc;
        int n;
        host_addr = a;
        host_we   = w;
        host_req  = 1'b1;
        if (early) begin
            step();
            host_req  = 1'b0;
            host_addr = 23'($urandom);
            host_we   = 1'($urandom);
            repeat (10) step();
        end else begin
            got = 0;
            n   = 0;
            while (!got && n < 200) begin
                @(negedge C7M);
                n++;
                if (host_ack === 1'b1) begin
                    got = 1;
                end else begin
                    sc = (busy === 1'b1);
                    step();
                    if (sc) begin
                        host_addr = 23'($urandom);
                        host_we   = 1'($urandom);
                    end
                end
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL ack_timeout got=no_ack want=ack addr=%h", a);
            end
            step();
            host_req = 1'b0;
        end
    endtask

    initial begin
        int  rc;
        int  n;
        bit  found;
        zero_bit  = 1'b0;
        RES       = 1'b1;
        host_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = '0;
        slot_ok   = 1'b0;
        repeat (3) step();
        do_reset(rc);

        // Fast instance: debt 2 at offset 10, overflow set by offset 24 and sticky.
        wait_neg(rc + 10);
        checks++;
        if (f_debt !== 3'd2 || f_ovf !== 1'b0) begin
            errors++;
            $display("FAIL fast_early got debt=%0d ovf=%b want debt=2 ovf=0", f_debt, f_ovf);
        end
        wait_neg(rc + 40);
        checks++;
        if (f_ovf !== 1'b1) begin
            errors++;
            $display("FAIL fast_overflow got=%b want=1", f_ovf);
        end
        step();

        host_xfer(23'h000A5C, 1'b0, 1'b0);
        repeat (3) step();
        host_xfer(23'h400000, 1'b1, 1'b0);
        repeat (3) step();
        host_xfer(23'h2ABCDE, 1'b0, 1'b1);

        do_reset(rc);
        slot_mode = 1;
        repeat (250) step();

        slot_mode = 0;
        do_reset(rc);
        while (cyc < rc + 4 * REF_INTERVAL) step();
        host_xfer(23'h1F0F0F, 1'b0, 1'b0);
        repeat (20) step();

        // Abort an access in its first CAS cycle.
        host_addr = 23'($urandom);
        host_we   = 1'($urandom);
        host_req  = 1'b1;
        found = 0;
        n = 0;
        while (!found && n < 50) begin
            @(negedge C7M);
            n++;
            if (nRAS === 1'b0 && nCAS0 === 1'b1 && nCAS1 === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ras_timeout got=no_ras want=ras");
        end
        step();
        step();
        RES      = 1'b1;
        host_req = 1'b0;
        step();
        RES = 1'b0;
        repeat (12) step();

        slot_mode = 2;
        for (int i = 0; i < 40; i++) begin
            host_xfer(23'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 15)) step();
        end
        repeat (30) step();

        checks++;
        if (hq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain got acks=%0d refreshes=%0d pending want=0", hq.size(), rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
